// File: rtl/b11_feeder_if.sv
// Bus bundle between the b11 feeder, its upstream word source, the scrambler
// core and the response consumer.
//   master : the feeder (drives in_ready, x_in, stbi, rsp_*, busy)
//   slave  : the environment (drives in_valid, in_data, x_out, rsp_ready)
// Optional macro FEEDER_SEQ_EN adds the 8-bit rsp_seq response tag.
interface b11_feeder_if;
    localparam int unsigned DATA_W = 6;
    localparam int unsigned SEQ_W  = 8;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] x_in;
    logic              stbi;
    logic [DATA_W-1:0] x_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_drop;
    logic              busy;
`ifdef FEEDER_SEQ_EN
    logic [SEQ_W-1:0]  rsp_seq;

    modport master (
        input  in_valid, in_data, x_out, rsp_ready,
        output in_ready, x_in, stbi, rsp_valid, rsp_data, rsp_drop, busy, rsp_seq
    );
    modport slave (
        output in_valid, in_data, x_out, rsp_ready,
        input  in_ready, x_in, stbi, rsp_valid, rsp_data, rsp_drop, busy, rsp_seq
    );
`else
    modport master (
        input  in_valid, in_data, x_out, rsp_ready,
        output in_ready, x_in, stbi, rsp_valid, rsp_data, rsp_drop, busy
    );
    modport slave (
        output in_valid, in_data, x_out, rsp_ready,
        input  in_ready, x_in, stbi, rsp_valid, rsp_data, rsp_drop, busy
    );
`endif
endinterface

// File: rtl/b11_feeder.sv
// Upstream initiator for the 6-bit scrambler core. Accepts one word at a time
// from a valid/ready source, commits it to the core with a one-cycle low pulse
// on stbi, waits out the core latency, samples x_out and returns it as a
// valid/ready response. Words in the core's reject range (27..62) skip the
// long wait and are reported as drops with data 0.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   bus (master)      : in_valid/in_ready/in_data upstream, x_in/stbi/x_out to
//                       the core, rsp_valid/rsp_ready/rsp_data/rsp_drop
//                       response, busy status
// Optional macro FEEDER_SEQ_EN: adds bus.rsp_seq, an 8-bit response counter.
// Parameter limits: STARTUP_CYC >= 2, 9 <= WAIT_CYC <= 63, DROP_CYC >= 2.
module b11_feeder #(
    parameter int unsigned STARTUP_CYC = 4,
    parameter int unsigned WAIT_CYC    = 12,
    parameter int unsigned DROP_CYC    = 2
) (
    input  logic         clock,
    input  logic         reset,
    b11_feeder_if.master bus
);
    localparam int unsigned DATA_W  = 6;
    localparam int unsigned DROP_LO = 27;
    localparam int unsigned DROP_HI = 62;
    localparam int unsigned MAX_AB  = (STARTUP_CYC > WAIT_CYC) ? STARTUP_CYC : WAIT_CYC;
    localparam int unsigned CNT_MAX = (MAX_AB > DROP_CYC) ? MAX_AB : DROP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        IDLE = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              drop_q,      drop_d;
    logic [DATA_W-1:0] x_in_q,      x_in_d;
    logic              stbi_q,      stbi_d;
    logic              in_ready_q,  in_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_drop_q,  rsp_drop_d;
    logic              busy_q,      busy_d;

    logic accept_c;
    logic sample_c;
    logic rsp_hs_c;
    logic in_drop_c;

    // Handshake and range-check qualifiers
    assign accept_c  = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign sample_c  = (state_q == WAIT) && (cnt_q == '0);
    assign rsp_hs_c  = (state_q == RESP) && rsp_valid_q && bus.rsp_ready;
    assign in_drop_c = (bus.in_data >= DATA_W'(DROP_LO)) && (bus.in_data <= DATA_W'(DROP_HI));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= BOOT;
            cnt_q       <= CNT_W'(STARTUP_CYC - 1);
            drop_q      <= 1'b0;
            x_in_q      <= '0;
            stbi_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_drop_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            x_in_q      <= x_in_d;
            stbi_q      <= stbi_d;
            in_ready_q  <= in_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_drop_q  <= rsp_drop_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        case (state_q)
            BOOT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            IDLE: begin
                if (accept_c) begin
                    drop_d  = in_drop_c;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d   = drop_q ? CNT_W'(DROP_CYC - 1) : CNT_W'(WAIT_CYC - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (sample_c) state_d = RESP;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP: begin
                if (rsp_hs_c) state_d = IDLE;
            end
            default: state_d = BOOT;
        endcase
    end

    // Registered outputs, computed for the state being entered
    always_comb begin
        x_in_d      = x_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_drop_d  = rsp_drop_q;
        stbi_d      = (state_d != SEND);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        // x_in only moves on acceptance, so the core always re-latches a stable word
        if (accept_c) x_in_d = bus.in_data;
        if (sample_c) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = drop_q ? '0 : bus.x_out;
            rsp_drop_d  = drop_q;
        end
        if (rsp_hs_c) rsp_valid_d = 1'b0;
    end

    assign bus.x_in      = x_in_q;
    assign bus.stbi      = stbi_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_drop  = rsp_drop_q;
    assign bus.busy      = busy_q;

`ifdef FEEDER_SEQ_EN
    localparam int unsigned SEQ_W = 8;

    logic [SEQ_W-1:0] seq_q, seq_d;

    // Response tag: advances once per completed response, drops included
    always_comb begin
        seq_d = seq_q;
        if (rsp_hs_c) seq_d = seq_q + SEQ_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) seq_q <= '0;
        else       seq_q <= seq_d;
    end

    assign bus.rsp_seq = seq_q;
`endif

endmodule
